// File: rtl/timer_multi.sv
// Multi-channel bus timer: NCH up-counters with power-of-two prescalers,
// reload, one-shot/periodic mode and sticky write-1-to-ack pending flags.
module timer_multi #(
  parameter int NCH   = 2,
  parameter int WIDTH = 16
) (
  input  logic                    bus_clk,
  input  logic                    rst,
  input  logic [$clog2(NCH)+1:0]  addr,
  input  logic                    write,
  input  logic [15:0]             bus_in,
  output logic [15:0]             bus_out,
  output logic                    irq,
  output logic [NCH-1:0]          irq_vec
);

  localparam int AW = $clog2(NCH) + 2;

  localparam logic [1:0] REG_CNT    = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_RELOAD = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [AW-1:0] ch_field;
  int unsigned   sel_ch;
  logic          sel_ok;
  logic [1:0]    reg_sel;

  assign ch_field = addr >> 2;
  assign sel_ch   = 32'(ch_field);
  assign sel_ok   = (sel_ch < 32'(NCH));
  assign reg_sel  = addr[1:0];

  logic [15:0]    rd_cnt    [NCH];
  logic [15:0]    rd_ctrl   [NCH];
  logic [15:0]    rd_reload [NCH];
  logic [15:0]    rd_stat   [NCH];
  logic [NCH-1:0] irq_src;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d, reload_q, reload_d;
    logic [15:0]      pre_q, pre_d, pre_max;
    logic [3:0]       div_q, div_d;
    logic             en_q, en_d, os_q, os_d, ie_q, ie_d, pend_q, pend_d;
    logic             wr_ch, tick, ovf;

    assign wr_ch   = write && sel_ok && (sel_ch == 32'(g));
    assign pre_max = 16'((17'd1 << div_q) - 17'd1);
    assign tick    = en_q && (pre_q == pre_max);
    // A CNT write in the same cycle swallows the overflow entirely.
    assign ovf     = tick && (cnt_q == '1) && !(wr_ch && reg_sel == REG_CNT);

    always_comb begin
      cnt_d    = cnt_q;
      reload_d = reload_q;
      pre_d    = pre_q;
      div_d    = div_q;
      en_d     = en_q;
      os_d     = os_q;
      ie_d     = ie_q;
      pend_d   = pend_q;

      if (en_q) pre_d = tick ? 16'd0 : pre_q + 16'd1;
      if (tick) cnt_d = (cnt_q == '1) ? reload_q : cnt_q + WIDTH'(1);

      if (wr_ch && reg_sel == REG_STATUS && bus_in[0]) pend_d = 1'b0;
      if (ovf) begin
        pend_d = 1'b1;
        if (os_q) en_d = 1'b0;
      end

      if (wr_ch) begin
        case (reg_sel)
          REG_CNT: begin
            cnt_d = bus_in[WIDTH-1:0];
            pre_d = 16'd0;
          end
          REG_CTRL: begin
            en_d  = bus_in[0];
            os_d  = bus_in[1];
            ie_d  = bus_in[2];
            div_d = bus_in[7:4];
            pre_d = 16'd0;
          end
          REG_RELOAD: reload_d = bus_in[WIDTH-1:0];
          default: ;
        endcase
      end
    end

    always_ff @(posedge bus_clk) begin
      if (!rst) begin
        cnt_q    <= '0;
        reload_q <= '0;
        pre_q    <= '0;
        div_q    <= '0;
        en_q     <= 1'b0;
        os_q     <= 1'b0;
        ie_q     <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        reload_q <= reload_d;
        pre_q    <= pre_d;
        div_q    <= div_d;
        en_q     <= en_d;
        os_q     <= os_d;
        ie_q     <= ie_d;
        pend_q   <= pend_d;
      end
    end

    assign rd_cnt[g]    = 16'(cnt_q);
    assign rd_ctrl[g]   = {8'h00, div_q, 1'b0, ie_q, os_q, en_q};
    assign rd_reload[g] = 16'(reload_q);
    assign rd_stat[g]   = {14'd0, en_q, pend_q};
    assign irq_src[g]   = pend_q & ie_q;
  end

  logic [15:0]    bus_out_q, bus_out_d;
  logic           irq_q;
  logic [NCH-1:0] irq_vec_q;

  always_comb begin
    bus_out_d = 16'd0;
    for (int c = 0; c < NCH; c++) begin
      if (sel_ch == 32'(c)) begin
        case (reg_sel)
          REG_CNT:    bus_out_d = rd_cnt[c];
          REG_CTRL:   bus_out_d = rd_ctrl[c];
          REG_RELOAD: bus_out_d = rd_reload[c];
          default:    bus_out_d = rd_stat[c];
        endcase
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!rst) begin
      bus_out_q <= 16'd0;
      irq_q     <= 1'b0;
      irq_vec_q <= '0;
    end else begin
      bus_out_q <= bus_out_d;
      irq_q     <= |irq_src;
      irq_vec_q <= irq_src;
    end
  end

  assign bus_out = bus_out_q;
  assign irq     = irq_q;
  assign irq_vec = irq_vec_q;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi (NCH=2, WIDTH=16): counting, overflow,
// one-shot, ack precedence, CNT-write precedence and mid-count reset.
module tb_timer_multi;

  logic        bus_clk;
  logic        rst;
  logic [2:0]  addr;
  logic        write;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        irq;
  logic [1:0]  irq_vec;

  int n_cmp = 0;
  int n_err = 0;

  timer_multi #(.NCH(2), .WIDTH(16)) dut (
    .bus_clk (bus_clk),
    .rst     (rst),
    .addr    (addr),
    .write   (write),
    .bus_in  (bus_in),
    .bus_out (bus_out),
    .irq     (irq),
    .irq_vec (irq_vec)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge bus_clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    addr   = a;
    bus_in = d;
    write  = 1'b1;
    @(posedge bus_clk);
    #1;
    write  = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    addr  = a;
    write = 1'b0;
    @(posedge bus_clk);
    #1;
    d = bus_out;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b0;
    idle(3);
    n_cmp++;
    if (irq !== 1'b0 || irq_vec !== 2'b00 || bus_out !== 16'h0) begin
      n_err++;
      $display("FAIL reset_out irq=%b vec=%b bus_out=%h want 0/00/0000", irq, irq_vec, bus_out);
    end
    rst = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), v);
      n_cmp++;
      if (v !== 16'h0) begin
        n_err++;
        $display("FAIL reset_reg addr=%0d got %h want 0000", a, v);
      end
    end
  endtask

  task automatic test_count();
    logic [15:0] exp_cnt [5];
    exp_cnt = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h1000, 16'h1001};
    bus_wr(3'd2, 16'h1000);
    bus_wr(3'd0, 16'hFFFD);
    bus_wr(3'd1, 16'h0005);
    addr = 3'd0;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      n_cmp++;
      if (bus_out !== exp_cnt[k]) begin
        n_err++;
        $display("FAIL count_seq k=%0d got %h want %h", k, bus_out, exp_cnt[k]);
      end
      if (k == 2 || k == 3) begin
        n_cmp++;
        if (irq !== (k == 3)) begin
          n_err++;
          $display("FAIL count_irq k=%0d got %b want %b", k, irq, (k == 3));
        end
      end
    end
  endtask

  task automatic test_ack();
    bus_wr(3'd3, 16'h0001);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL ack_irq_lag got %b want 1", irq);
    end
    addr = 3'd3;
    idle(1);
    n_cmp++;
    if (bus_out !== 16'h0002 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL ack_clear status=%h irq=%b want 0002/0", bus_out, irq);
    end
  endtask

  task automatic test_ack_on_overflow();
    bus_wr(3'd0, 16'hFFFE);
    idle(1);
    bus_wr(3'd3, 16'h0001);
    addr = 3'd3;
    idle(1);
    n_cmp++;
    if (bus_out !== 16'h0003) begin
      n_err++;
      $display("FAIL ack_ovf_status got %h want 0003", bus_out);
    end
    addr = 3'd0;
    idle(1);
    n_cmp++;
    if (bus_out !== 16'h1001) begin
      n_err++;
      $display("FAIL ack_ovf_cnt got %h want 1001", bus_out);
    end
  endtask

  task automatic test_cnt_write_on_overflow();
    bus_wr(3'd3, 16'h0001);
    bus_wr(3'd0, 16'hFFFE);
    idle(1);
    bus_wr(3'd0, 16'h0123);
    addr = 3'd3;
    idle(1);
    n_cmp++;
    if (bus_out !== 16'h0002) begin
      n_err++;
      $display("FAIL cntwr_status got %h want 0002", bus_out);
    end
    addr = 3'd0;
    idle(1);
    n_cmp++;
    if (bus_out !== 16'h0124 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL cntwr_cnt cnt=%h irq=%b want 0124/0", bus_out, irq);
    end
    bus_wr(3'd1, 16'h0000);
  endtask

  task automatic test_oneshot();
    logic [15:0] v;
    bus_wr(3'd6, 16'h0042);
    bus_wr(3'd4, 16'hFFFF);
    n_cmp++;
    if (bus_out !== 16'h0000) begin
      n_err++;
      $display("FAIL same_cycle_rd got %h want 0000", bus_out);
    end
    bus_wr(3'd5, 16'h0027);
    addr = 3'd4;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      if (k >= 3) begin
        n_cmp++;
        if (bus_out !== ((k == 3) ? 16'hFFFF : 16'h0042) ||
            irq_vec !== ((k == 3) ? 2'b00 : 2'b10)) begin
          n_err++;
          $display("FAIL oneshot_ovf k=%0d cnt=%h vec=%b want %h/%b", k, bus_out, irq_vec,
                   (k == 3) ? 16'hFFFF : 16'h0042, (k == 3) ? 2'b00 : 2'b10);
        end
      end
    end
    idle(100);
    bus_rd(3'd4, v);
    n_cmp++;
    if (v !== 16'h0042) begin
      n_err++;
      $display("FAIL oneshot_frozen got %h want 0042", v);
    end
    bus_rd(3'd7, v);
    n_cmp++;
    if (v !== 16'h0001) begin
      n_err++;
      $display("FAIL oneshot_status got %h want 0001", v);
    end
    bus_rd(3'd5, v);
    n_cmp++;
    if (v !== 16'h0026 || irq !== 1'b1 || irq_vec !== 2'b10) begin
      n_err++;
      $display("FAIL oneshot_ctrl ctrl=%h irq=%b vec=%b want 0026/1/10", v, irq, irq_vec);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] v;
    bus_wr(3'd1, 16'h0005);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    n_cmp++;
    if (irq !== 1'b0 || irq_vec !== 2'b00 || bus_out !== 16'h0) begin
      n_err++;
      $display("FAIL midrst_out irq=%b vec=%b bus_out=%h want 0/00/0000", irq, irq_vec, bus_out);
    end
    idle(5);
    bus_rd(3'd0, v);
    n_cmp++;
    if (v !== 16'h0) begin
      n_err++;
      $display("FAIL midrst_cnt0 got %h want 0000", v);
    end
    bus_rd(3'd1, v);
    n_cmp++;
    if (v !== 16'h0) begin
      n_err++;
      $display("FAIL midrst_ctrl0 got %h want 0000", v);
    end
    bus_rd(3'd7, v);
    n_cmp++;
    if (v !== 16'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_stat1 got %h irq=%b want 0000/0", v, irq);
    end
  endtask

  initial begin
    rst    = 1'b0;
    addr   = 3'd0;
    write  = 1'b0;
    bus_in = 16'h0;
    #1;
    test_reset();
    test_count();
    test_ack();
    test_ack_on_overflow();
    test_cnt_write_on_overflow();
    test_oneshot();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
